// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory-stage sequencer.
// Contents:
//   CPU_WORD_W / CPU_LINK_LSB - default data width and the link-compare granularity
//   word_t                    - machine word
//   memctl_state_t            - memory-stage sequencer states
package cpu_types_pkg;

  localparam int CPU_WORD_W   = 32;
  localparam int CPU_LINK_LSB = 2;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DDONE  = 2'd1,
    HALTED = 2'd2
  } memctl_state_t;

endpackage

// File: rtl/llsc_link.sv
// LL/SC link register.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   set_i           - LL completes this cycle; link_addr takes set_addr_i
//   clr_i           - SC or matching plain store completes this cycle
//   set_addr_i      - address recorded by an LL
//   cmp_addr_i      - address compared against the link (the current EX/M address)
//   snoop_inv_i     - coherence invalidate strobe
//   snoop_addr_i    - invalidated address
//   link_valid_o    - link currently held
//   addr_match_o    - link_addr and cmp_addr_i name the same word
module llsc_link
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = CPU_WORD_W,
  parameter int LINK_LSB = CPU_LINK_LSB
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic [WORD_W-1:0] cmp_addr_i,
  input  logic              snoop_inv_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  output logic              link_valid_o,
  output logic              addr_match_o
);

  logic              link_valid_q, link_valid_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;
  logic              snoop_hit_old_s;
  logic              snoop_hit_new_s;

  // Word-granular compares; the low LINK_LSB bits never distinguish a link.
  assign addr_match_o    = (link_addr_q[WORD_W-1:LINK_LSB] == cmp_addr_i[WORD_W-1:LINK_LSB]);
  assign snoop_hit_old_s = snoop_inv_i &
                           (snoop_addr_i[WORD_W-1:LINK_LSB] == link_addr_q[WORD_W-1:LINK_LSB]);
  assign snoop_hit_new_s = snoop_inv_i &
                           (snoop_addr_i[WORD_W-1:LINK_LSB] == set_addr_i[WORD_W-1:LINK_LSB]);
  assign link_valid_o    = link_valid_q;

  // Next link state: an LL overrides the old link, but a snoop to the new
  // address in the same cycle still kills it; clears then snoops otherwise.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (set_i) begin
      link_valid_d = ~snoop_hit_new_s;
      link_addr_d  = set_addr_i;
    end else if (clr_i) begin
      link_valid_d = 1'b0;
    end else if (snoop_hit_old_s) begin
      link_valid_d = 1'b0;
    end else begin
      link_valid_d = link_valid_q;
    end
  end

  // Link register flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl_chk.sv
// Protocol checker for the memory-stage sequencer inputs.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   dren_i        - latched load request
//   dwen_i        - latched store request
module mem_stage_ctrl_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic dren_i,
  input logic dwen_i
);

  // A latched instruction is never both a load and a store.
  a_no_rw : assert property (@(posedge clk_i) disable iff (!rst_ni) !(dren_i && dwen_i))
    else $error("mem_stage_ctrl: m_dREN and m_dWEN both set");

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer behind the EX/M latch.
// Issues dcache requests from the latched EX/M fields, produces the global
// advance (pipe_en), holds a finished access until the icache also hits,
// handles HALT and owns the LL/SC link.
// Ports:
//   CLK, nRST                 - clock, asynchronous active-low reset
//   ihit, dhit                - icache hit, dcache hit/ack
//   m_dREN, m_dWEN, m_datomic - latched load / store / atomic (LL, SC)
//   m_addr, m_halt            - latched data address, latched HALT
//   flush_req                 - hazard unit EX/M flush request
//   dmemload                  - dcache read data
//   snoop_inv, snoop_addr     - coherence invalidate strobe and address
//   dmemREN, dmemWEN, dmemaddr- dcache request
//   m_load, sc_result         - load data and SC result toward M/WB
//   pipe_en, exm_flush        - pipeline advance, EX/M clear on advance
//   halt_out                  - sticky halt
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = CPU_WORD_W,
  parameter int LINK_LSB = CPU_LINK_LSB
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              m_dREN,
  input  logic              m_dWEN,
  input  logic              m_datomic,
  input  logic [WORD_W-1:0] m_addr,
  input  logic              m_halt,
  input  logic              flush_req,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] m_load,
  output logic [WORD_W-1:0] sc_result,
  output logic              pipe_en,
  output logic              exm_flush,
  output logic              halt_out
);

  memctl_state_t     state_q, state_d;
  logic [WORD_W-1:0] held_load_q, held_load_d;
  logic              held_sc_q, held_sc_d;
  logic              halt_q, halt_d;

  logic              link_valid_s;
  logic              addr_match_s;
  logic              sc_ok_s;
  logic              sc_fail_s;
  logic              mem_req_s;
  logic              in_run_s;
  logic              link_set_s;
  logic              link_clr_s;

  assign sc_ok_s   = m_dWEN & m_datomic & link_valid_s & addr_match_s;
  assign sc_fail_s = m_dWEN & m_datomic & ~sc_ok_s;
  // A failing SC never reaches the dcache, so it does not wait for dhit.
  assign mem_req_s = m_dREN | (m_dWEN & ~sc_fail_s);
  assign in_run_s  = (state_q == RUN);
  assign dmemaddr  = m_addr;
  assign halt_out  = halt_q;

  // Link events happen only where the access completes in RUN. A failing SC
  // completes when the pipe advances; reads win if both requests are set.
  assign link_set_s = in_run_s & dhit & m_dREN & m_datomic;
  assign link_clr_s = in_run_s & ~m_dREN & m_dWEN &
                      (m_datomic ? (sc_ok_s ? dhit : pipe_en)
                                 : (dhit & link_valid_s & addr_match_s));

  llsc_link #(
    .WORD_W   (WORD_W),
    .LINK_LSB (LINK_LSB)
  ) u_link (
    .clk_i        (CLK),
    .rst_ni       (nRST),
    .set_i        (link_set_s),
    .clr_i        (link_clr_s),
    .set_addr_i   (m_addr),
    .cmp_addr_i   (m_addr),
    .snoop_inv_i  (snoop_inv),
    .snoop_addr_i (snoop_addr),
    .link_valid_o (link_valid_s),
    .addr_match_o (addr_match_s)
  );

  mem_stage_ctrl_chk u_chk (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .dren_i (m_dREN),
    .dwen_i (m_dWEN)
  );

  // State register with held load data / SC result and sticky halt.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      held_load_q <= '0;
      held_sc_q   <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_load_q <= held_load_d;
      held_sc_q   <= held_sc_d;
      halt_q      <= halt_d;
    end
  end

  // Next-state logic; the SC outcome is frozen on the dhit cycle.
  always_comb begin
    state_d     = state_q;
    held_load_d = held_load_q;
    held_sc_d   = held_sc_q;
    halt_d      = halt_q;
    case (state_q)
      RUN: begin
        if (mem_req_s & dhit & ~ihit) begin
          state_d     = DDONE;
          held_load_d = dmemload;
          held_sc_d   = sc_ok_s;
        end else if (m_halt & ~mem_req_s & ihit) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DDONE: begin
        if (ihit) begin
          state_d = RUN;
        end else begin
          state_d = DDONE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output decode; everything except dmemaddr is forced low during reset.
  always_comb begin
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    m_load    = '0;
    sc_result = '0;
    pipe_en   = 1'b0;
    if (nRST) begin
      case (state_q)
        RUN: begin
          dmemREN   = m_dREN;
          dmemWEN   = m_dWEN & ~sc_fail_s;
          m_load    = dmemload;
          sc_result = {{(WORD_W-1){1'b0}}, sc_ok_s};
          pipe_en   = ihit & (~mem_req_s | dhit);
        end
        DDONE: begin
          m_load    = held_load_q;
          sc_result = {{(WORD_W-1){1'b0}}, held_sc_q};
          pipe_en   = ihit;
        end
        HALTED: begin
          pipe_en = 1'b0;
        end
        default: begin
          pipe_en = 1'b0;
        end
      endcase
    end else begin
      pipe_en = 1'b0;
    end
    exm_flush = flush_req & pipe_en;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, m_dREN, m_dWEN, m_datomic, m_halt, flush_req, snoop_inv;
  logic [31:0] m_addr, dmemload, snoop_addr;
  logic        dmemREN, dmemWEN, pipe_en, exm_flush, halt_out;
  logic [31:0] dmemaddr, m_load, sc_result;

  int total = 0;
  int bad   = 0;

  // Reference model: a finished access waiting for ihit, halted, and the link.
  logic        md_wait, md_halt, md_lv, md_hs;
  logic [31:0] md_la, md_hl;

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .m_dREN(m_dREN), .m_dWEN(m_dWEN),
    .m_datomic(m_datomic), .m_addr(m_addr), .m_halt(m_halt), .flush_req(flush_req),
    .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .m_load(m_load),
    .sc_result(sc_result), .pipe_en(pipe_en), .exm_flush(exm_flush), .halt_out(halt_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return (a / 32'd4) == (b / 32'd4);
  endfunction

  // Compare against the model at the current inputs, then advance the model
  // across the next rising edge. Called just after a falling edge.
  task automatic step();
    logic ok, fail, req, e_pipe;
    logic n_wait, n_halt, n_lv, n_hs;
    logic [31:0] n_la, n_hl;
    #1;
    ok   = m_dWEN && m_datomic && md_lv && same_word(md_la, m_addr);
    fail = m_dWEN && m_datomic && !ok;
    req  = m_dREN || (m_dWEN && !fail);
    if (!nRST) begin
      e_pipe = 1'b0;
      chk("m_ren_rst", dmemREN, 32'd0);
      chk("m_wen_rst", dmemWEN, 32'd0);
      chk("m_load_rst", m_load, 32'd0);
      chk("m_sc_rst", sc_result, 32'd0);
    end else if (md_halt) begin
      e_pipe = 1'b0;
      chk("m_ren_halt", dmemREN, 32'd0);
      chk("m_wen_halt", dmemWEN, 32'd0);
    end else if (md_wait) begin
      e_pipe = ihit;
      chk("m_ren_done", dmemREN, 32'd0);
      chk("m_wen_done", dmemWEN, 32'd0);
      chk("m_load_done", m_load, md_hl);
      chk("m_sc_done", sc_result, {31'd0, md_hs});
    end else begin
      e_pipe = ihit && (!req || dhit);
      chk("m_ren", dmemREN, {31'd0, m_dREN});
      chk("m_wen", dmemWEN, {31'd0, m_dWEN && !fail});
      chk("m_load", m_load, dmemload);
      chk("m_sc", sc_result, {31'd0, ok});
    end
    chk("m_pipe", pipe_en, {31'd0, e_pipe});
    chk("m_flush", exm_flush, {31'd0, flush_req && e_pipe});
    chk("m_halt_out", halt_out, {31'd0, md_halt && nRST});
    chk("m_addr", dmemaddr, m_addr);
    if (!nRST) begin
      n_wait = 1'b0; n_halt = 1'b0; n_lv = 1'b0; n_la = 32'd0; n_hl = 32'd0; n_hs = 1'b0;
    end else begin
      n_wait = md_wait; n_halt = md_halt; n_lv = md_lv; n_la = md_la; n_hl = md_hl; n_hs = md_hs;
      if (!md_halt && !md_wait) begin
        if (m_dREN && m_datomic && dhit) begin
          n_lv = 1'b1; n_la = m_addr;
        end else if (!m_dREN && m_dWEN && m_datomic && (ok ? dhit : e_pipe)) begin
          n_lv = 1'b0;
        end else if (!m_dREN && m_dWEN && !m_datomic && dhit && md_lv && same_word(md_la, m_addr)) begin
          n_lv = 1'b0;
        end
        if (req && dhit && !ihit) begin
          n_wait = 1'b1; n_hl = dmemload; n_hs = ok;
        end else if (m_halt && !req && ihit) begin
          n_halt = 1'b1;
        end
      end else if (md_wait && ihit) begin
        n_wait = 1'b0;
      end
      if (snoop_inv && n_lv && same_word(snoop_addr, n_la)) n_lv = 1'b0;
    end
    @(posedge CLK);
    md_wait = n_wait; md_halt = n_halt; md_lv = n_lv; md_la = n_la; md_hl = n_hl; md_hs = n_hs;
    @(negedge CLK);
  endtask

  task automatic idle();
    m_dREN = 1'b0; m_dWEN = 1'b0; m_datomic = 1'b0; m_halt = 1'b0; flush_req = 1'b0;
    snoop_inv = 1'b0; snoop_addr = 32'd0; ihit = 1'b1; dhit = 1'b0;
  endtask

  task automatic op(input int kind, input logic [31:0] a, input logic ih, input logic dh);
    // kind: 0 none, 1 load, 2 store, 3 LL, 4 SC
    m_dREN = (kind == 1) || (kind == 3);
    m_dWEN = (kind == 2) || (kind == 4);
    m_datomic = (kind == 3) || (kind == 4);
    m_addr = a; ihit = ih; dhit = dh;
  endtask

  task automatic do_reset();
    idle(); nRST = 1'b0; step(); nRST = 1'b1;
  endtask

  typedef struct {
    int          kind;
    logic        hlt, ih, dh, fl;
    logic [31:0] addr;
    logic        e_ren, e_wen, e_pipe, e_flush;
  } vec_t;

  function automatic vec_t mk(input int k, input logic h, input logic ih, input logic dh,
                              input logic fl, input logic [31:0] a, input logic r,
                              input logic w, input logic p, input logic f);
    vec_t v;
    v.kind = k; v.hlt = h; v.ih = ih; v.dh = dh; v.fl = fl; v.addr = a;
    v.e_ren = r; v.e_wen = w; v.e_pipe = p; v.e_flush = f;
    return v;
  endfunction

  vec_t vt[10];

  initial begin
    logic [31:0] apool [4];
    apool[0] = 32'h80; apool[1] = 32'h84; apool[2] = 32'h83; apool[3] = 32'h100;
    md_wait = 1'b0; md_halt = 1'b0; md_lv = 1'b0; md_la = 32'd0; md_hl = 32'd0; md_hs = 1'b0;
    idle(); m_addr = 32'd0; dmemload = 32'hA5A5_0001; nRST = 1'b0;
    @(negedge CLK);

    // RUN decode from a clean reset (no link held).
    vt[0] = mk(1, 0, 1, 1, 1, 32'h40, 1, 0, 1, 1);
    vt[1] = mk(1, 0, 1, 0, 1, 32'h40, 1, 0, 0, 0);
    vt[2] = mk(2, 0, 1, 1, 0, 32'h44, 0, 1, 1, 0);
    vt[3] = mk(2, 0, 0, 1, 0, 32'h44, 0, 1, 0, 0);
    vt[4] = mk(4, 0, 1, 0, 1, 32'h80, 0, 0, 1, 1);
    vt[5] = mk(4, 0, 0, 1, 0, 32'h80, 0, 0, 0, 0);
    vt[6] = mk(0, 0, 1, 0, 1, 32'h0,  0, 0, 1, 1);
    vt[7] = mk(0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0);
    vt[8] = mk(0, 1, 1, 0, 0, 32'h0,  0, 0, 1, 0);
    vt[9] = mk(3, 0, 0, 0, 0, 32'h80, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle();
      op(vt[i].kind, vt[i].addr, vt[i].ih, vt[i].dh);
      m_halt = vt[i].hlt; flush_req = vt[i].fl;
      nRST = 1'b0;
      #1;
      chk("tbl_rst_pipe", pipe_en, 32'd0);
      chk("tbl_rst_ren", dmemREN, 32'd0);
      chk("tbl_rst_addr", dmemaddr, vt[i].addr);
      step();
      nRST = 1'b1;
      #1;
      chk("tbl_ren", dmemREN, {31'd0, vt[i].e_ren});
      chk("tbl_wen", dmemWEN, {31'd0, vt[i].e_wen});
      chk("tbl_pipe", pipe_en, {31'd0, vt[i].e_pipe});
      chk("tbl_flush", exm_flush, {31'd0, vt[i].e_flush});
      step();
    end

    // 1) load with dhit on the third cycle
    do_reset();
    op(1, 32'h40, 1, 0); dmemload = 32'h1111_1111;
    for (int c = 0; c < 2; c++) begin
      #1; chk("s1_ren", dmemREN, 32'd1); chk("s1_pipe_wait", pipe_en, 32'd0); step();
    end
    dhit = 1'b1; dmemload = 32'h1234_5678;
    #1; chk("s1_ren3", dmemREN, 32'd1); chk("s1_pipe3", pipe_en, 32'd1);
    chk("s1_load", m_load, 32'h1234_5678); step();

    // 2) dhit without ihit -> held load until ihit
    op(1, 32'h40, 0, 1); dmemload = 32'hDEAD_BEEF;
    #1; chk("s2_pipe0", pipe_en, 32'd0); step();
    dhit = 1'b0; dmemload = 32'd0;
    for (int c = 0; c < 2; c++) begin
      #1; chk("s2_ren", dmemREN, 32'd0); chk("s2_hold", m_load, 32'hDEAD_BEEF);
      chk("s2_pipe", pipe_en, 32'd0); step();
    end
    ihit = 1'b1;
    #1; chk("s2_pipe_ih", pipe_en, 32'd1); chk("s2_hold_ih", m_load, 32'hDEAD_BEEF); step();
    idle(); step();

    // 3) LL/SC address compare
    op(3, 32'h80, 1, 1); step();
    op(4, 32'h84, 1, 0);
    #1; chk("s3_scf_wen", dmemWEN, 32'd0); chk("s3_scf_res", sc_result, 32'd0);
    chk("s3_scf_pipe", pipe_en, 32'd1); step();
    op(3, 32'h80, 1, 1); step();
    op(4, 32'h80, 1, 1);
    #1; chk("s3_sc_wen", dmemWEN, 32'd1); chk("s3_sc_res", sc_result, 32'd1); step();
    idle(); step();

    // 4) snoops around LL/SC
    op(3, 32'h80, 1, 1); step();
    idle(); snoop_inv = 1'b1; snoop_addr = 32'h80; step();
    snoop_inv = 1'b0; op(4, 32'h80, 1, 1);
    #1; chk("s4a_res", sc_result, 32'd0); chk("s4a_wen", dmemWEN, 32'd0); step();
    op(3, 32'h80, 1, 1); step();
    idle(); snoop_inv = 1'b1; snoop_addr = 32'h100; step();
    snoop_inv = 1'b0; op(4, 32'h80, 1, 1);
    #1; chk("s4b_res", sc_result, 32'd1); chk("s4b_wen", dmemWEN, 32'd1); step();
    op(3, 32'h80, 1, 1); snoop_inv = 1'b1; snoop_addr = 32'h80; step();
    snoop_inv = 1'b0; op(4, 32'h80, 1, 1);
    #1; chk("s4c_res", sc_result, 32'd0); step();
    op(3, 32'h80, 1, 1); step();
    op(4, 32'h80, 0, 1); step();
    dhit = 1'b0; snoop_inv = 1'b1; snoop_addr = 32'h80;
    #1; chk("s4d_held", sc_result, 32'd1); chk("s4d_wen", dmemWEN, 32'd0); step();
    snoop_inv = 1'b0; ihit = 1'b1;
    #1; chk("s4d_held_ih", sc_result, 32'd1); chk("s4d_pipe", pipe_en, 32'd1); step();
    idle(); step();

    // 6) reset during DDONE; flush while stalled
    op(3, 32'h80, 1, 1); step();
    op(1, 32'h40, 0, 1); dmemload = 32'h5555_AAAA; step();
    ihit = 1'b0; dhit = 1'b0; nRST = 1'b0;
    #1; chk("s6_rst_ren", dmemREN, 32'd0); chk("s6_rst_load", m_load, 32'd0);
    chk("s6_rst_pipe", pipe_en, 32'd0); step();
    nRST = 1'b1; op(4, 32'h80, 1, 1);
    #1; chk("s6_link_clr", sc_result, 32'd0); chk("s6_wen", dmemWEN, 32'd0); step();
    op(1, 32'h40, 1, 0); flush_req = 1'b1;
    #1; chk("s6_flush_stall", exm_flush, 32'd0); step();
    dhit = 1'b1;
    #1; chk("s6_flush_adv", exm_flush, 32'd1); step();
    idle(); step();

    // 5) halt is sticky and freezes the pipe
    m_halt = 1'b1;
    #1; chk("s5_pipe_take", pipe_en, 32'd1); step();
    for (int c = 0; c < 20; c++) begin
      op((c % 3 == 0) ? 1 : 0, 32'h40, c[0], ~c[1]); m_halt = c[2];
      #1; chk("s5_halt", halt_out, 32'd1); chk("s5_pipe", pipe_en, 32'd0); step();
    end
    do_reset();
    #1; chk("s5_halt_clr", halt_out, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      nRST = ($urandom_range(0, 39) != 0);
      op($urandom_range(0, 5) % 5, apool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)));
      m_halt = ($urandom_range(0, 59) == 0);
      flush_req = 1'($urandom_range(0, 1));
      snoop_inv = ($urandom_range(0, 3) == 0);
      snoop_addr = apool[$urandom_range(0, 3)];
      dmemload = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
